mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_if.sv | 19 +
 rtl/mem_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// Data-cache bus between the memory stage (master) and the data cache (slave).
interface mem_stage_if;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dmemren;
  logic        dmemwen;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;

  modport master (
    input  dhit, dmemload,
    output dmemren, dmemwen, dmemaddr, dmemstore
  );

  modport slave (
    output dhit, dmemload,
    input  dmemren, dmemwen, dmemaddr, dmemstore
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: EX/MEM and MEM/WB latches, data-cache access FSM, load buffer.
// state  | meaning
// IDLE   | no access outstanding, or a new access is being issued this cycle
// WAIT   | access issued, cache has not answered yet
// DONE   | access finished but pipeline not advancing; request held off
module mem_stage (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_ihit,
  input  logic               i_flush,
  input  logic [31:0]        i_npc_next,
  input  logic               i_dren_next,
  input  logic               i_dwen_next,
  input  logic               i_regwr_next,
  input  logic [1:0]         i_regsel_next,
  input  logic [4:0]         i_regdst_next,
  input  logic [31:0]        i_aluout_next,
  input  logic [31:0]        i_store_data,
  mem_stage_if.master        dbus,
  output logic               o_mem_stall,
  output logic               o_fwd_regwr,
  output logic [4:0]         o_fwd_regdst,
  output logic [31:0]        o_fwd_data,
  output logic               o_wb_regwr,
  output logic [4:0]         o_wb_regdst,
  output logic [31:0]        o_wb_wdat
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_em_npc;
  logic        r_em_dren;
  logic        r_em_dwen;
  logic        r_em_regwr;
  logic [1:0]  r_em_regsel;
  logic [4:0]  r_em_regdst;
  logic [31:0] r_em_aluout;
  logic [31:0] r_em_store;

  logic        r_wb_regwr;
  logic [4:0]  r_wb_regdst;
  logic [1:0]  r_wb_regsel;
  logic [31:0] r_wb_aluout;
  logic [31:0] r_wb_npc;
  logic [31:0] r_wb_ldata;

  logic [31:0] r_ldbuf;

  logic        w_memop;
  logic        w_req;
  logic        w_hit;
  logic        w_stall;
  logic        w_adv;
  logic [31:0] w_ldata;

  always_comb begin
    w_memop = r_em_dren | r_em_dwen;
    w_req   = w_memop & ((r_state == S_IDLE) | (r_state == S_WAIT));
    w_hit   = w_req & dbus.dhit;
    w_stall = w_req & ~dbus.dhit;
    w_adv   = i_ihit & ~w_stall;
    // only a hit on a live request is trusted; otherwise the buffer holds the answer
    w_ldata = w_hit ? dbus.dmemload : r_ldbuf;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_stall)    w_state_nxt = S_WAIT;
        else if (w_hit) w_state_nxt = w_adv ? S_IDLE : S_DONE;
      end
      S_WAIT: begin
        if (w_hit) w_state_nxt = w_adv ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        if (w_adv) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_ldbuf <= '0;
    else if (w_hit) r_ldbuf <= dbus.dmemload;
  end

  // flush is harmless during a stall: advance is low, so EX simply re-presents it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_em_npc    <= '0;
      r_em_dren   <= 1'b0;
      r_em_dwen   <= 1'b0;
      r_em_regwr  <= 1'b0;
      r_em_regsel <= '0;
      r_em_regdst <= '0;
      r_em_aluout <= '0;
      r_em_store  <= '0;
    end else if (w_adv) begin
      if (i_flush) begin
        r_em_npc    <= '0;
        r_em_dren   <= 1'b0;
        r_em_dwen   <= 1'b0;
        r_em_regwr  <= 1'b0;
        r_em_regsel <= '0;
        r_em_regdst <= '0;
        r_em_aluout <= '0;
        r_em_store  <= '0;
      end else begin
        r_em_npc    <= i_npc_next;
        r_em_dren   <= i_dren_next;
        r_em_dwen   <= i_dwen_next;
        r_em_regwr  <= i_regwr_next;
        r_em_regsel <= i_regsel_next;
        r_em_regdst <= i_regdst_next;
        r_em_aluout <= i_aluout_next;
        r_em_store  <= i_store_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_regwr  <= 1'b0;
      r_wb_regdst <= '0;
      r_wb_regsel <= '0;
      r_wb_aluout <= '0;
      r_wb_npc    <= '0;
      r_wb_ldata  <= '0;
    end else if (w_adv) begin
      r_wb_regwr  <= r_em_regwr;
      r_wb_regdst <= r_em_regdst;
      r_wb_regsel <= r_em_regsel;
      r_wb_aluout <= r_em_aluout;
      r_wb_npc    <= r_em_npc;
      r_wb_ldata  <= w_ldata;
    end
  end

  always_comb begin
    dbus.dmemwen   = w_req & r_em_dwen;
    dbus.dmemren   = w_req & r_em_dren & ~r_em_dwen;
    dbus.dmemaddr  = w_req ? r_em_aluout : '0;
    dbus.dmemstore = w_req ? r_em_store : '0;
    o_mem_stall    = w_stall;
    o_fwd_regwr    = r_em_regwr;
    o_fwd_regdst   = r_em_regdst;
    o_fwd_data     = (r_em_regsel == 2'b10) ? r_em_npc : r_em_aluout;
    o_wb_regwr     = r_wb_regwr;
    o_wb_regdst    = r_wb_regdst;
    unique case (r_wb_regsel)
      2'b01:   o_wb_wdat = r_wb_ldata;
      2'b10:   o_wb_wdat = r_wb_npc;
      default: o_wb_wdat = r_wb_aluout;
    endcase
  end

endmodule
